// File: rtl/io_frontend_if.sv
// Pad-side bus of io_frontend: raw buttons, sensor words and mode selects in,
// synchronised reset, tick, debounced buttons and status LEDs out.
interface io_frontend_if #(
   parameter int NUM_BTN   = 4,
   parameter int DIV_WIDTH = 8,
   parameter int DATA_W    = 16,
   parameter int LED_W     = 8
);
   logic [NUM_BTN-1:0]   btn;
   logic [DIV_WIDTH-1:0] div_sel;
   logic [DATA_W-1:0]    x_data;
   logic [DATA_W-1:0]    y_data;
   logic [1:0]           led_mode;
   logic                 rst_sync;
   logic                 tick;
   logic [NUM_BTN-1:0]   btn_level;
   logic [NUM_BTN-1:0]   btn_press;
   logic [NUM_BTN-1:0]   btn_release;
   logic [LED_W-1:0]     led;

   modport master (
      output btn, div_sel, x_data, y_data, led_mode,
      input  rst_sync, tick, btn_level, btn_press, btn_release, led
   );

   modport slave (
      input  btn, div_sel, x_data, y_data, led_mode,
      output rst_sync, tick, btn_level, btn_press, btn_release, led
   );
endinterface

// File: rtl/io_frontend.sv
// Board glue: reset synchroniser, tick enable, button debounce and LED mux.
// Define IO_FRONTEND_REPEAT_EN to add auto-repeat press pulses on held buttons.
module io_frontend #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DIV_WIDTH       = 8,
   parameter int DATA_W          = 16,
   parameter int LED_W           = 8,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_RATE     = 8
) (
   input logic         clk,
   input logic         rst,
   io_frontend_if.slave bus
);
   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HALF = LED_W / 2;
   localparam int HB_W = LED_W + 4;

   logic [1:0]           rst_pipe;
   logic                 rst_int;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic                 tick_q;
   logic                 tick_next;
   logic [NUM_BTN-1:0]   sync_a;
   logic [NUM_BTN-1:0]   sync_b;
   logic [NUM_BTN-1:0]   level_q;
   logic [NUM_BTN-1:0]   press_q;
   logic [NUM_BTN-1:0]   release_q;
   logic [NUM_BTN-1:0]   flip;
   logic [NUM_BTN-1:0]   rep_fire;
   logic [CW-1:0]        stab [NUM_BTN];
   logic [7:0]           press_cnt;
   logic [HB_W-1:0]      hb;
   logic [LED_W-1:0]     led_q;
   logic [LED_W-1:0]     led_imu;
   logic [LED_W-1:0]     led_btn;
   logic [LED_W-1:0]     led_cnt;
   logic [LED_W-1:0]     led_hb;
   logic                 unused_imu;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_pipe <= '0;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_int = rst_pipe[1];

   // Lowering div_sel below the running count wraps at once via the >= compare.
   assign tick_next = (div_cnt >= bus.div_sel);

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q  <= tick_next;
         div_cnt <= tick_next ? '0 : div_cnt + 1'b1;
      end
   end

   always_comb begin
      flip = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         flip[i] = (sync_b[i] != level_q[i]) && (stab[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
   end

`ifdef IO_FRONTEND_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0]      rep_cnt [NUM_BTN];
   logic [NUM_BTN-1:0] rep_armed;

   // Ticks are counted only while the level is steadily high; armed selects delay vs rate.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (level_q[i] && !flip[i] && tick_next) begin
            rep_fire[i] = rep_armed[i] ? (rep_cnt[i] == RW'(REPEAT_RATE - 1))
                                       : (rep_cnt[i] == RW'(REPEAT_DELAY - 1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         rep_armed <= '0;
         for (int i = 0; i < NUM_BTN; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!level_q[i] || flip[i]) begin
               rep_cnt[i]   <= '0;
               rep_armed[i] <= 1'b0;
            end else if (tick_next) begin
               if (rep_fire[i]) begin
                  rep_cnt[i]   <= '0;
                  rep_armed[i] <= 1'b1;
               end else begin
                  rep_cnt[i] <= rep_cnt[i] + 1'b1;
               end
            end
         end
      end
   end
`else
   assign rep_fire = '0;
`endif

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         sync_a    <= '0;
         sync_b    <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) stab[i] <= '0;
      end else begin
         sync_a    <= bus.btn;
         sync_b    <= sync_a;
         level_q   <= level_q ^ flip;
         press_q   <= (flip & ~level_q) | rep_fire;
         release_q <= flip & level_q;
         for (int i = 0; i < NUM_BTN; i++) begin
            if ((sync_b[i] == level_q[i]) || flip[i]) begin
               stab[i] <= '0;
            end else begin
               stab[i] <= stab[i] + 1'b1;
            end
         end
      end
   end

   assign led_imu    = {bus.x_data[DATA_W-1 -: HALF], bus.y_data[DATA_W-1 -: HALF]};
   assign led_btn    = LED_W'(level_q);
   assign led_cnt    = LED_W'(press_cnt);
   assign led_hb     = hb[HB_W-1 -: LED_W];
   assign unused_imu = ^{bus.x_data, bus.y_data};

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         press_cnt <= '0;
         hb        <= '0;
         led_q     <= '0;
      end else begin
         if (|press_q) press_cnt <= press_cnt + 1'b1;
         if (tick_q) hb <= hb + 1'b1;
         case (bus.led_mode)
            2'd0:    led_q <= led_imu;
            2'd1:    led_q <= led_btn;
            2'd2:    led_q <= led_cnt;
            default: led_q <= led_hb;
         endcase
      end
   end

   assign bus.rst_sync    = rst_int;
   assign bus.tick        = tick_q;
   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
   assign bus.led         = led_q;
endmodule

// File: tb/tb_io_frontend.sv
// Randomised and directed bench for io_frontend against a history-based reference model.
// Honours IO_FRONTEND_REPEAT_EN the same way the design does.
module tb_io_frontend;
   localparam int NUM_BTN      = 4;
   localparam int DC           = 16;
   localparam int DIV_WIDTH    = 8;
   localparam int DATA_W       = 16;
   localparam int LED_W        = 8;
   localparam int REPEAT_DELAY = 32;
   localparam int REPEAT_RATE  = 8;
   localparam int HALF         = LED_W / 2;

   logic clk;
   logic rst;
   int   test_count;
   int   fail_count;

   io_frontend_if #(.NUM_BTN(NUM_BTN), .DIV_WIDTH(DIV_WIDTH), .DATA_W(DATA_W), .LED_W(LED_W)) bus ();

   io_frontend #(
      .NUM_BTN(NUM_BTN), .DEBOUNCE_CYCLES(DC), .DIV_WIDTH(DIV_WIDTH), .DATA_W(DATA_W),
      .LED_W(LED_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, advanced once per rising edge from the pad-level rules.
   bit                 m_rs1, m_rs2;
   int                 m_cnt;
   bit                 m_tick;
   bit [NUM_BTN-1:0]   m_level, m_press, m_release;
   bit [NUM_BTN-1:0]   hist [$];
   int                 m_pcnt;
   int                 m_hb;
   logic [LED_W-1:0]   m_led;
   int                 m_held [NUM_BTN];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic model_clear();
      m_cnt     = 0;
      m_tick    = 1'b0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      hist.delete();
      repeat (DC + 2) hist.push_back('0);
      m_pcnt = 0;
      m_hb   = 0;
      m_led  = '0;
      for (int i = 0; i < NUM_BTN; i++) m_held[i] = 0;
   endtask

   // A level flips once the DC samples that have crossed the synchroniser all disagree with it.
   task automatic model_step();
      bit               old_rs;
      bit               old_tick;
      bit [NUM_BTN-1:0] old_level, old_press, flip;
      int               old_pcnt, old_hb, xt, yt;
      bit               tick_now, all_diff;
      old_rs = m_rs2;
      if (!rst) begin
         m_rs1 = 1'b0;
         m_rs2 = 1'b0;
      end else begin
         m_rs2 = m_rs1;
         m_rs1 = 1'b1;
      end
      if (!rst || !old_rs) begin
         model_clear();
      end else begin
         old_tick  = m_tick;
         old_level = m_level;
         old_press = m_press;
         old_pcnt  = m_pcnt;
         old_hb    = m_hb;
         tick_now  = (m_cnt >= int'(bus.div_sel));
         m_cnt     = tick_now ? 0 : m_cnt + 1;
         m_tick    = tick_now;
         hist.push_back(bus.btn);
         void'(hist.pop_front());
         flip = '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) if (hist[j][i] == old_level[i]) all_diff = 1'b0;
            flip[i] = all_diff;
         end
         m_level   = old_level ^ flip;
         m_press   = flip & ~old_level;
         m_release = flip & old_level;
`ifdef IO_FRONTEND_REPEAT_EN
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!old_level[i] || flip[i]) begin
               m_held[i] = 0;
            end else if (tick_now) begin
               m_held[i]++;
               if (m_held[i] == REPEAT_DELAY ||
                   (m_held[i] > REPEAT_DELAY && (m_held[i] - REPEAT_DELAY) % REPEAT_RATE == 0))
                  m_press[i] = 1'b1;
            end
         end
`endif
         m_pcnt = (old_pcnt + ((|old_press) ? 1 : 0)) % 256;
         m_hb   = (old_hb + (old_tick ? 1 : 0)) % (1 << (LED_W + 4));
         xt     = int'(bus.x_data) >> (DATA_W - HALF);
         yt     = int'(bus.y_data) >> (DATA_W - HALF);
         case (bus.led_mode)
            2'd0:    m_led = LED_W'((xt << HALF) | yt);
            2'd1:    m_led = LED_W'(old_level);
            2'd2:    m_led = LED_W'(old_pcnt);
            default: m_led = LED_W'(old_hb >> 4);
         endcase
      end
   endtask

   task automatic compare_outputs();
      checkOutput("rst_sync", 32'(bus.rst_sync), 32'(m_rs2));
      checkOutput("tick", 32'(bus.tick), 32'(m_tick));
      checkOutput("btn_level", 32'(bus.btn_level), 32'(m_level));
      checkOutput("btn_press", 32'(bus.btn_press), 32'(m_press));
      checkOutput("btn_release", 32'(bus.btn_release), 32'(m_release));
      checkOutput("led", 32'(bus.led), 32'(m_led));
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         model_step();
         compare_outputs();
      end
   endtask

   task automatic applyStimulus(input logic [NUM_BTN-1:0] b, input int cycles);
      bus.btn = b;
      run_cycles(cycles);
   endtask

   task automatic wait_level(input int ch, input bit val, input int limit, output int n);
      n = 0;
      while (bus.btn_level[ch] !== val && n < limit) begin
         run_cycles(1);
         n++;
      end
   endtask

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         run_cycles(1);
         n++;
      end while (bus.tick !== 1'b1 && n < limit);
   endtask

   initial begin
      int n;
      int pulses;
      int first_rep;
      int toggle_div;
      test_count   = 0;
      fail_count   = 0;
      rst          = 1'b0;
      bus.btn      = '0;
      bus.div_sel  = 8'd3;
      bus.x_data   = '0;
      bus.y_data   = '0;
      bus.led_mode = 2'd0;
      m_rs1        = 1'b0;
      m_rs2        = 1'b0;
      model_clear();

      run_cycles(5);
      checkOutput("reset_rst_sync", 32'(bus.rst_sync), 32'd0);
      checkOutput("reset_led", 32'(bus.led), 32'd0);
      rst = 1'b1;
      run_cycles(1);
      checkOutput("rst_sync_edge1", 32'(bus.rst_sync), 32'd0);
      run_cycles(1);
      checkOutput("rst_sync_edge2", 32'(bus.rst_sync), 32'd1);

      wait_tick(20, n);
      checkOutput("first_tick_delay", n, 4);
      wait_tick(20, n);
      checkOutput("tick_period_4", n, 4);
      run_cycles(2);
      bus.div_sel = 8'd0;
      run_cycles(1);
      checkOutput("tick_after_lower", 32'(bus.tick), 32'd1);
      run_cycles(1);
      checkOutput("tick_every_cycle", 32'(bus.tick), 32'd1);
      bus.div_sel = 8'd255;
      wait_tick(300, n);
      wait_tick(300, n);
      checkOutput("tick_period_256", n, 256);

      applyStimulus(4'b0001, 10);
      applyStimulus(4'b0000, 30);
      checkOutput("glitch_level", 32'(bus.btn_level), 32'd0);

      bus.btn = 4'b0100;
      wait_level(2, 1'b1, 40, n);
      checkOutput("press_latency", n, 18);
      checkOutput("press_pulse", 32'(bus.btn_press), 32'h4);
      run_cycles(1);
      checkOutput("press_single", 32'(bus.btn_press), 32'h0);
      bus.btn = 4'b0000;
      wait_level(2, 1'b0, 40, n);
      checkOutput("release_latency", n, 18);
      checkOutput("release_pulse", 32'(bus.btn_release), 32'h4);

      bus.led_mode = 2'd2;
      bus.btn      = 4'b1001;
      wait_level(0, 1'b1, 40, n);
      checkOutput("simul_press", 32'(bus.btn_press), 32'h9);
      run_cycles(2);
      checkOutput("press_count_2", 32'(bus.led), 32'd2);
      applyStimulus(4'b0000, 20);
      for (int k = 0; k < 254; k++) begin
         applyStimulus(4'b0010, 20);
         applyStimulus(4'b0000, 20);
      end
      run_cycles(2);
      checkOutput("press_wrap", 32'(bus.led), 32'd0);

      bus.led_mode = 2'd0;
      bus.x_data   = 16'hA5C3;
      bus.y_data   = 16'h3F00;
      run_cycles(1);
      checkOutput("led_mode0", 32'(bus.led), 32'hA3);
      applyStimulus(4'b0101, 20);
      bus.led_mode = 2'd1;
      run_cycles(1);
      checkOutput("led_mode1", 32'(bus.led), 32'h05);
      applyStimulus(4'b0000, 20);

      bus.led_mode = 2'd3;
      bus.div_sel  = 8'd0;
      run_cycles(2);
      bus.btn = 4'b0010;
      wait_level(1, 1'b1, 40, n);
      pulses    = bus.btn_press[1] ? 1 : 0;
      first_rep = -1;
      for (int k = 1; k <= 60; k++) begin
         run_cycles(1);
         if (bus.btn_press[1]) begin
            pulses++;
            if (first_rep < 0) first_rep = k;
         end
      end
`ifdef IO_FRONTEND_REPEAT_EN
      checkOutput("repeat_pulses", pulses, 5);
      checkOutput("repeat_first", first_rep, 32);
`else
      checkOutput("repeat_pulses", pulses, 1);
`endif
      applyStimulus(4'b0000, 25);

      toggle_div = 4;
      for (int c = 0; c < 4000; c++) begin
         if (c % 400 == 0) toggle_div = ($urandom_range(0, 1) == 0) ? 4 : 30;
         for (int i = 0; i < NUM_BTN; i++)
            if ($urandom_range(0, toggle_div - 1) == 0) bus.btn[i] = ~bus.btn[i];
         if ($urandom_range(0, 99) == 0) bus.div_sel = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) bus.led_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) begin
            bus.x_data = 16'($urandom);
            bus.y_data = 16'($urandom);
         end
         rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
         run_cycles(1);
      end
      rst = 1'b1;
      run_cycles(5);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end
endmodule
